// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    // Requester IDs double as bit positions in the two-bit request/grant vectors.
    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    localparam int ARB_TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: on a tie, the requester not served last wins.
module rr_arbiter2
    import riscv_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req[REQ_I] && req[REQ_D]) begin
            if (last_grant == REQ_D) begin
                gnt[REQ_I] = 1'b1;
            end else begin
                gnt[REQ_D] = 1'b1;
            end
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data accesses, one
// transaction at a time, with round-robin tie-break and a wait timeout.
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic                i_err,
    output logic [DATA_W-1:0]   i_rdata,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic                d_err,
    output logic [DATA_W-1:0]   d_rdata,

    output logic                m_req,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_be,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_ready
);

    localparam int BE_W = DATA_W / 8;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t        state_q, state_d;
    logic              lastGrant_q, lastGrant_d;
    logic [CNT_W-1:0]  waitCnt_q, waitCnt_d;
    logic [ADDR_W-1:0] mAddr_q, mAddr_d;
    logic [DATA_W-1:0] mWdata_q, mWdata_d;
    logic [BE_W-1:0]   mBe_q, mBe_d;
    logic              mWe_q, mWe_d;
    logic              iRvalid_q, iRvalid_d, iErr_q, iErr_d;
    logic [DATA_W-1:0] iRdata_q, iRdata_d;
    logic              dRvalid_q, dRvalid_d, dErr_q, dErr_d;
    logic [DATA_W-1:0] dRdata_q, dRdata_d;

    logic [1:0]        pick;
    logic              compValid, compErr;
    logic [DATA_W-1:0] compData;

    // Bit order matches REQ_I = 0, REQ_D = 1.
    rr_arbiter2 u_rr (
        .req        ({d_req, i_req}),
        .last_grant (lastGrant_q),
        .gnt        (pick)
    );

    assign i_gnt = (state_q == IDLE) && !rst && pick[REQ_I];
    assign d_gnt = (state_q == IDLE) && !rst && pick[REQ_D];

    // m_req derives from the state register so an async reset drops it at once.
    assign m_req   = (state_q != IDLE);
    assign m_we    = mWe_q;
    assign m_addr  = mAddr_q;
    assign m_wdata = mWdata_q;
    assign m_be    = mBe_q;

    assign i_rvalid = iRvalid_q;
    assign i_err    = iErr_q;
    assign i_rdata  = iRdata_q;
    assign d_rvalid = dRvalid_q;
    assign d_err    = dErr_q;
    assign d_rdata  = dRdata_q;

    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        waitCnt_d   = waitCnt_q;
        mAddr_d     = mAddr_q;
        mWdata_d    = mWdata_q;
        mBe_d       = mBe_q;
        mWe_d       = mWe_q;
        iRvalid_d   = 1'b0;
        iErr_d      = 1'b0;
        iRdata_d    = iRdata_q;
        dRvalid_d   = 1'b0;
        dErr_d      = 1'b0;
        dRdata_d    = dRdata_q;
        compValid   = 1'b0;
        compErr     = 1'b0;
        compData    = '0;

        case (state_q)
            IDLE: begin
                if (i_gnt) begin
                    state_d     = BUSY_I;
                    lastGrant_d = REQ_I;
                    waitCnt_d   = '0;
                    mAddr_d     = i_addr;
                    mWdata_d    = '0;
                    mBe_d       = '1;
                    mWe_d       = 1'b0;
                end else if (d_gnt) begin
                    state_d     = BUSY_D;
                    lastGrant_d = REQ_D;
                    waitCnt_d   = '0;
                    mAddr_d     = d_addr;
                    mWdata_d    = d_wdata;
                    mBe_d       = d_be;
                    mWe_d       = d_we;
                end
            end
            BUSY_I, BUSY_D: begin
                // A ready on the final allowed cycle still wins over the timeout.
                if (m_ready) begin
                    compValid = 1'b1;
                    compData  = mWe_q ? '0 : m_rdata;
                end else if (waitCnt_q == CNT_LAST) begin
                    compValid = 1'b1;
                    compErr   = 1'b1;
                end else begin
                    waitCnt_d = waitCnt_q + 1'b1;
                end
                if (compValid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (compValid) begin
            if (state_q == BUSY_I) begin
                iRvalid_d = 1'b1;
                iErr_d    = compErr;
                iRdata_d  = compData;
            end else begin
                dRvalid_d = 1'b1;
                dErr_d    = compErr;
                dRdata_d  = compData;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lastGrant_q <= REQ_D;
            waitCnt_q   <= '0;
            mAddr_q     <= '0;
            mWdata_q    <= '0;
            mBe_q       <= '0;
            mWe_q       <= 1'b0;
            iRvalid_q   <= 1'b0;
            iErr_q      <= 1'b0;
            iRdata_q    <= '0;
            dRvalid_q   <= 1'b0;
            dErr_q      <= 1'b0;
            dRdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            waitCnt_q   <= waitCnt_d;
            mAddr_q     <= mAddr_d;
            mWdata_q    <= mWdata_d;
            mBe_q       <= mBe_d;
            mWe_q       <= mWe_d;
            iRvalid_q   <= iRvalid_d;
            iErr_q      <= iErr_d;
            iRdata_q    <= iRdata_d;
            dRvalid_q   <= dRvalid_d;
            dErr_q      <= dErr_d;
            dRdata_q    <= dRdata_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single transactions from a vector
// table, plus round-robin, throughput and mid-transaction reset sequences.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, i_gnt, i_rvalid, i_err;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic [BW-1:0] d_be;
    logic          m_req, m_we, m_ready;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [BW-1:0] m_be;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(15)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_err    (i_err),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_be     (d_be),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_err    (d_err),
        .d_rdata  (d_rdata),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_be     (m_be),
        .m_rdata  (m_rdata),
        .m_ready  (m_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          isData;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
        int            readyAfter;
        logic [DW-1:0] memData;
        logic [DW-1:0] expRdata;
        logic          expErr;
        int            expReqCycles;
        logic          expMWe;
        logic [BW-1:0] expMBe;
    } vec_t;

    vec_t vecs[8];
    int   checks = 0;
    int   errors = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        logic [DW-1:0] seenRdata;
        logic          seenErr, gotValid, fieldsOk, wrongPort;
        int            reqCycles, cyc;
        seenRdata = '0; seenErr = 1'b0; gotValid = 1'b0;
        fieldsOk = 1'b1; wrongPort = 1'b0; reqCycles = 0; cyc = 0;
        if (v.isData) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_be = v.be;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        #1;
        checkOutput($sformatf("v%0d gnt", idx), {62'd0, i_gnt, d_gnt}, v.isData ? 64'd1 : 64'd2);
        tick();
        i_req = 1'b0;
        d_req = 1'b0;
        for (int k = 0; k < 40 && !gotValid; k++) begin
            #1;
            if (v.isData ? (i_rvalid || i_err) : (d_rvalid || d_err)) wrongPort = 1'b1;
            if (v.isData ? d_rvalid : i_rvalid) begin
                gotValid  = 1'b1;
                seenRdata = v.isData ? d_rdata : i_rdata;
                seenErr   = v.isData ? d_err : i_err;
                checkOutput($sformatf("v%0d m_req_at_done", idx), {63'd0, m_req}, 64'd0);
            end else begin
                if (m_req) begin
                    reqCycles++;
                    if (m_addr !== v.addr || m_we !== v.expMWe || m_be !== v.expMBe ||
                        (v.isData && v.we && m_wdata !== v.wdata)) fieldsOk = 1'b0;
                end
                m_ready = (cyc == v.readyAfter);
                m_rdata = v.memData;
                tick();
                m_ready = 1'b0;
                cyc++;
            end
        end
        checkOutput($sformatf("v%0d rvalid_seen", idx), {63'd0, gotValid}, 64'd1);
        checkOutput($sformatf("v%0d rdata", idx), {32'd0, seenRdata}, {32'd0, v.expRdata});
        checkOutput($sformatf("v%0d err", idx), {63'd0, seenErr}, {63'd0, v.expErr});
        checkOutput($sformatf("v%0d m_req_cycles", idx), 64'(reqCycles), 64'(v.expReqCycles));
        checkOutput($sformatf("v%0d fields_stable", idx), {63'd0, fieldsOk}, 64'd1);
        checkOutput($sformatf("v%0d wrong_port", idx), {63'd0, wrongPort}, 64'd0);
        tick();
        checkOutput($sformatf("v%0d rvalid_one_cycle", idx), {62'd0, i_rvalid, d_rvalid}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] order;
        int         gntCyc[4];
        int         nG, nTot, iRv, dRv;
        logic       both, dSeen;

        vecs[0] = '{1'b0, 1'b0, 32'h10,  32'h0,        4'h0,    0,  32'h00500113, 32'h00500113, 1'b0, 1,  1'b0, 4'hF};
        vecs[1] = '{1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'b0011, 3,  32'h11111111, 32'h0,        1'b0, 4,  1'b1, 4'b0011};
        vecs[2] = '{1'b1, 1'b0, 32'h200, 32'h0,        4'hF,    1,  32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 2,  1'b0, 4'hF};
        vecs[3] = '{1'b1, 1'b0, 32'h300, 32'h0,        4'hF,    99, 32'h55555555, 32'h0,        1'b1, 15, 1'b0, 4'hF};
        vecs[4] = '{1'b0, 1'b0, 32'h14,  32'h0,        4'h0,    0,  32'h12345678, 32'h12345678, 1'b0, 1,  1'b0, 4'hF};
        vecs[5] = '{1'b1, 1'b1, 32'h104, 32'h1,        4'h0,    0,  32'h22222222, 32'h0,        1'b0, 1,  1'b1, 4'h0};
        vecs[6] = '{1'b0, 1'b0, 32'h18,  32'h0,        4'h0,    14, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 15, 1'b0, 4'hF};
        vecs[7] = '{1'b0, 1'b0, 32'h1C,  32'h0,        4'h0,    99, 32'h0BADF00D, 32'h0,        1'b1, 15, 1'b0, 4'hF};

        rst = 1'b1; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        i_addr = 32'h4; d_addr = 32'h8; d_wdata = '0; d_be = '1;
        m_ready = 1'b0; m_rdata = '0;
        tick();
        tick();
        checkOutput("reset gnt", {62'd0, i_gnt, d_gnt}, 64'd0);
        checkOutput("reset m_req", {63'd0, m_req}, 64'd0);
        checkOutput("reset rvalid_err", {60'd0, i_rvalid, i_err, d_rvalid, d_err}, 64'd0);
        checkOutput("reset m_fields", {27'd0, m_we, m_be, m_addr}, 64'd0);
        checkOutput("reset rdata", {i_rdata, d_rdata}, 64'd0);

        // Both requesters held from the first edge after reset.
        i_addr = 32'h40; d_addr = 32'h80;
        m_ready = 1'b1; m_rdata = 32'h77;
        rst = 1'b0;
        order = '0; nG = 0; nTot = 0; iRv = 0; dRv = 0; both = 1'b0;
        for (int c = 0; c < 14; c++) begin
            #1;
            if (i_gnt && d_gnt) both = 1'b1;
            if (i_gnt || d_gnt) begin
                nTot++;
                if (nG < 4) begin
                    order[nG] = d_gnt;
                    gntCyc[nG] = c;
                    nG++;
                end
            end
            iRv += int'(i_rvalid);
            dRv += int'(d_rvalid);
            tick();
            if (nG == 4) begin
                i_req = 1'b0;
                d_req = 1'b0;
            end
        end
        m_ready = 1'b0;
        checkOutput("rr order", {60'd0, order}, 64'b1010);
        checkOutput("rr grant_count", 64'(nTot), 64'd4);
        checkOutput("rr fourth_grant_cycle", 64'(gntCyc[3]), 64'd6);
        checkOutput("rr double_grant", {63'd0, both}, 64'd0);
        checkOutput("rr i_rvalid_count", 64'(iRv), 64'd2);
        checkOutput("rr d_rvalid_count", 64'(dRv), 64'd2);

        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v], v);
        end

        // Reset while a data load is waiting on memory.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_be = '1;
        #1;
        checkOutput("rst_mid d_gnt", {63'd0, d_gnt}, 64'd1);
        tick();
        d_req = 1'b0;
        tick();
        #1;
        checkOutput("rst_mid busy m_req", {63'd0, m_req}, 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid m_req async", {63'd0, m_req}, 64'd0);
        dSeen = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            dSeen = dSeen | d_rvalid | d_err;
        end
        rst = 1'b0;
        i_req = 1'b1; i_addr = 32'h20;
        #1;
        checkOutput("rst_mid i_gnt", {63'd0, i_gnt}, 64'd1);
        dSeen = dSeen | d_rvalid | d_err;
        tick();
        i_req = 1'b0;
        checkOutput("rst_mid fetch m_req", {63'd0, m_req}, 64'd1);
        checkOutput("rst_mid fetch m_addr", {32'd0, m_addr}, 64'h20);
        m_ready = 1'b1; m_rdata = 32'h13;
        dSeen = dSeen | d_rvalid | d_err;
        tick();
        m_ready = 1'b0;
        checkOutput("rst_mid i_rvalid", {63'd0, i_rvalid}, 64'd1);
        checkOutput("rst_mid i_rdata", {32'd0, i_rdata}, 64'h13);
        dSeen = dSeen | d_rvalid | d_err;
        checkOutput("rst_mid no d_rvalid", {63'd0, dSeen}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all ports.
REQ-002 Parameter DATA_W, default 32, data width of all ports; byte-enable width is DATA_W/8.
REQ-003 Parameter TIMEOUT, default 15, maximum cycles m_req is held without m_ready before abort.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 i_req  in  1  instruction-fetch read request, held until i_gnt.
REQ-007 i_addr  in  ADDR_W  fetch address.
REQ-008 i_gnt  out  1  fetch request accepted this cycle.
REQ-009 i_rvalid / i_err  out  1 / 1  fetch completion pulse / completion was a timeout abort.
REQ-010 i_rdata  out  DATA_W  fetch data, valid with i_rvalid.
REQ-011 d_req, d_we  in  1, 1  data request, held until d_gnt; write when d_we=1.
REQ-012 d_addr / d_wdata / d_be  in  ADDR_W / DATA_W / DATA_W/8  data address, store data, byte enables.
REQ-013 d_gnt, d_rvalid, d_err  out  1 each  data accept, completion pulse, timeout flag.
REQ-014 d_rdata  out  DATA_W  load data, valid with d_rvalid.
REQ-015 m_req, m_we  out  1, 1  shared memory request and write flag.
REQ-016 m_addr / m_wdata / m_be  out  ADDR_W / DATA_W / DATA_W/8  registered transaction fields.
REQ-017 m_rdata, m_ready  in  DATA_W, 1  memory read data; transfer complete this cycle.

Function
REQ-018 FSM states IDLE, BUSY_I, BUSY_D; exactly one transaction outstanding at any time.
REQ-019 In IDLE, any request is granted: i_gnt/d_gnt combinational, asserted only in IDLE, at most one per cycle.
REQ-020 On grant edge, fields are latched (fetch: m_we=0, m_be all ones) and state moves to BUSY_I/BUSY_D.
REQ-021 Simultaneous i_req and d_req: round-robin on last_grant; requester not served last wins.
REQ-022 In BUSY_x, m_req=1 with latched fields stable until m_ready sampled high or timeout.
REQ-023 m_ready high in BUSY_x: next cycle x_rvalid=1 for one cycle, x_rdata=m_rdata registered (0 for writes), x_err=0, m_req=0, state IDLE.
REQ-024 Minimum latency: grant cycle N, m_req cycle N+1, m_ready N+1 -> rvalid N+2; new grant allowed in rvalid cycle (one transaction per 2 cycles peak).
REQ-025 Wait counter cleared on grant, increments each BUSY cycle without m_ready; at TIMEOUT cycles: m_req drops, x_rvalid=1, x_err=1, x_rdata=0, state IDLE.
REQ-026 m_ready sampled in IDLE is ignored; m_ready on the TIMEOUT-th cycle counts as success.
REQ-027 Requests withdrawn before grant cause no transaction; requests while BUSY wait, never dropped.
REQ-028 d_we=1 with d_be=0 is issued as a normal write; completion still pulses d_rvalid.
REQ-029 Write completions: rdata=0; rvalid/err semantics identical to reads.

Reset
REQ-030 rst asserted: state IDLE, m_req=0, all rvalid/err/gnt=0, rdata and m_* fields 0, wait counter 0, last_grant=D (fetch wins first tie).
REQ-031 rst mid-transaction aborts it immediately: m_req low asynchronously, no rvalid/err pulse issued.
REQ-032 First grant is possible on the first rising edge after rst deasserts.

Structure
REQ-033 Shared package riscv_pkg holds arb_state_t (IDLE, BUSY_I, BUSY_D), requester-ID constants REQ_I/REQ_D, ARB_TIMEOUT_DEFAULT=15.
REQ-034 Two-way round-robin picker is one sub-module rr_arbiter2 (req[1:0], last_grant in, gnt one-hot out); FSM, field registers and timeout counter stay in top.

Verification
REQ-035 Fetch only: i_req, i_addr=0x00000010, m_ready next cycle, m_rdata=0x00500113 -> i_gnt cycle 0, m_req cycle 1, i_rvalid cycle 2 with i_rdata=0x00500113, i_err=0.
REQ-036 Simultaneous i_req/d_req after reset, both held -> fetch granted first, data next; alternation I,D,I,D over 4 completions.
REQ-037 Store d_addr=0x100, d_wdata=0xDEADBEEF, d_be=0b0011, m_ready after 3 wait cycles -> m_we=1, m_be=0011 stable 4 cycles, d_rvalid once, d_rdata=0.
REQ-038 m_ready never asserted -> m_req high exactly 15 cycles, then d_rvalid=1, d_err=1, d_rdata=0; next request serviced normally.
REQ-039 rst pulsed while BUSY_D with m_req high -> m_req low before next edge, no d_rvalid, first i_req after release granted immediately.
